// File: rtl/pwm_duty_load_ctrl_if.sv
// Byte-stream and duty-bank signals between the serial front end,
// the load controller and the channel register bank.
//
// Handshake: a byte transfers on a rising CLK edge where ByteValid,
// ByteReady and FrameActive are all 1. ByteReady depends only on
// controller state, never on ByteValid. ByteValid without ByteReady or
// FrameActive is dropped, and the source does not need to hold it.
interface pwm_duty_load_ctrl_if #(
  parameter int CHANNELS = 8,
  parameter int BitWidth = 8
);
  logic                FrameActive;
  logic                ByteValid;
  logic [7:0]          ByteIn;
  logic                ByteReady;
  logic [BitWidth-1:0] RegData;
  logic [CHANNELS-1:0] RegHold;
  logic                ErrFlag;

  // Host / serial receiver side.
  modport master (
    output FrameActive, ByteValid, ByteIn,
    input  ByteReady, RegData, RegHold, ErrFlag
  );

  // Controller side.
  modport slave (
    input  FrameActive, ByteValid, ByteIn,
    output ByteReady, RegData, RegHold, ErrFlag
  );
endinterface

// File: rtl/pwm_duty_load_ctrl.sv
// Duty-register load controller. Each frame is an address byte
// (bit7 AutoInc, bits[6:0] channel index) followed by data bytes. Each
// data byte causes a one-cycle registered one-hot RegHold pulse along
// with RegData. An out-of-range index raises a sticky ErrFlag, and the
// rest of the frame is discarded.
module pwm_duty_load_ctrl #(
  parameter int CHANNELS = 8,
  parameter int BitWidth = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  pwm_duty_load_ctrl_if.slave  bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_WRITE   = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [7:0] CH_COUNT = 8'(CHANNELS);
  localparam logic [6:0] LAST_IDX = 7'(CHANNELS - 1);

  state_t              state_q, state_d;
  logic [6:0]          idx_q, idx_d;
  logic                ai_q, ai_d;
  logic [BitWidth-1:0] data_q, data_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic                err_q, err_d;
  logic                ready;
  logic                accept;

  // ByteReady is a pure decode of the current state.
  always_comb begin
    ready = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DISCARD);
  end

  assign accept = bus.ByteValid & bus.FrameActive & ready;

  // Next-state and datapath decode. RegHold is computed here for the
  // DATA->WRITE transition so the registered pulse lines up with WRITE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ai_d    = ai_q;
    data_d  = data_q;
    hold_d  = '0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.FrameActive) begin
          state_d = S_ADDR;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (!bus.FrameActive) begin
          state_d = S_IDLE;
        end else if (accept) begin
          idx_d = bus.ByteIn[6:0];
          ai_d  = bus.ByteIn[7];
          if ({1'b0, bus.ByteIn[6:0]} < CH_COUNT) begin
            state_d = S_DATA;
          end else begin
            state_d = S_DISCARD;
            err_d   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (!bus.FrameActive) begin
          state_d = S_IDLE;
        end else if (accept) begin
          data_d  = bus.ByteIn[BitWidth-1:0];
          state_d = S_WRITE;
          for (int c = 0; c < CHANNELS; c++) begin
            hold_d[c] = (idx_q == 7'(c));
          end
        end
      end
      S_WRITE: begin
        // The pulse is never truncated; a dropped frame only ends after it.
        state_d = bus.FrameActive ? S_DATA : S_IDLE;
        if (ai_q) begin
          idx_d = (idx_q == LAST_IDX) ? 7'd0 : idx_q + 7'd1;
        end
      end
      S_DISCARD: begin
        if (!bus.FrameActive) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ai_q    <= 1'b0;
      data_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ai_q    <= ai_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign bus.ByteReady = ready;
  assign bus.RegData   = data_q;
  assign bus.RegHold   = hold_q;
  assign bus.ErrFlag   = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pwm_duty_load_ctrl.sv
// Bench for pwm_duty_load_ctrl: directed frames from the test plan,
// then random frames, checked against a frame-level model.
module tb_pwm_duty_load_ctrl;
  localparam int CHANNELS = 8;
  localparam int BitWidth = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] dbg_state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [7:0] m_last = '0;
  logic [7:0] fdata[8];

  pwm_duty_load_ctrl_if #(.CHANNELS(CHANNELS), .BitWidth(BitWidth)) bus ();

  pwm_duty_load_ctrl #(.CHANNELS(CHANNELS), .BitWidth(BitWidth)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Count RegHold pulses: values seen just before each rising edge.
  always @(posedge CLK) begin
    if (!RST && bus.RegHold != '0) begin
      pulses++;
      check("hold_onehot", 32'($onehot(bus.RegHold)), 32'd1);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Wait (bounded) for ready, then present one byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 1)) begin
      if (bus.ByteReady === 1'b1) tick();
    end
    while (bus.ByteReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.ByteReady !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    bus.ByteValid = 1'b1;
    bus.ByteIn    = b;
    tick();
    bus.ByteValid = 1'b0;
    bus.ByteIn    = 8'($urandom);
  endtask

  // One complete frame: address then n data bytes from fdata.
  task automatic run_frame(input logic [7:0] addr, input int n);
    int idx;
    bit ai, bad;
    bus.FrameActive = 1'b1;
    tick();
    check("err_clear", 32'(bus.ErrFlag), 32'd0);
    check("ready_addr", 32'(bus.ByteReady), 32'd1);
    send_byte(addr);
    idx = int'(addr[6:0]);
    ai  = addr[7];
    bad = (idx >= CHANNELS);
    check("err_addr", 32'(bus.ErrFlag), 32'(bad));
    check("hold_after_addr", 32'(bus.RegHold), 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(fdata[i]);
      if (!bad) begin
        check("hold_write", 32'(bus.RegHold), 32'd1 << idx);
        check("data_write", 32'(bus.RegData), 32'(fdata[i]));
        check("ready_write", 32'(bus.ByteReady), 32'd0);
        exp_pulses++;
        m_last = fdata[i];
        if (ai) idx = (idx + 1) % CHANNELS;
      end else begin
        check("hold_discard", 32'(bus.RegHold), 32'd0);
        check("ready_discard", 32'(bus.ByteReady), 32'd1);
      end
    end
    bus.FrameActive = 1'b0;
    tick();
    tick();
    check("idle_ready", 32'(bus.ByteReady), 32'd0);
    check("err_sticky", 32'(bus.ErrFlag), 32'(bad));
    check("data_holds", 32'(bus.RegData), 32'(m_last));
  endtask

  initial begin
    int n;
    logic [7:0] a;
    bus.FrameActive = 1'b0;
    bus.ByteValid   = 1'b0;
    bus.ByteIn      = 8'h00;

    // Reset values.
    repeat (3) tick();
    check("rst_hold", 32'(bus.RegHold), 32'd0);
    check("rst_data", 32'(bus.RegData), 32'd0);
    check("rst_ready", 32'(bus.ByteReady), 32'd0);
    check("rst_err", 32'(bus.ErrFlag), 32'd0);
    RST = 1'b0;
    tick();

    // Stray byte outside a frame is ignored.
    bus.ByteValid = 1'b1;
    bus.ByteIn    = 8'h01;
    tick();
    bus.ByteValid = 1'b0;
    check("stray_ready", 32'(bus.ByteReady), 32'd0);

    // Directed frames.
    fdata[0] = 8'hA5;
    run_frame(8'h03, 1);
    fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33;
    run_frame(8'h86, 3);
    fdata[0] = 8'h10; fdata[1] = 8'h20;
    run_frame(8'h02, 2);
    fdata[0] = 8'hFF;
    run_frame(8'h0A, 1);
    fdata[0] = 8'h5C;
    run_frame(8'h01, 1);

    // Frame drops right after the address: no write.
    bus.FrameActive = 1'b1;
    tick();
    send_byte(8'h05);
    bus.FrameActive = 1'b0;
    tick();
    check("drop_addr_hold", 32'(bus.RegHold), 32'd0);
    check("drop_addr_ready", 32'(bus.ByteReady), 32'd0);
    tick();

    // Frame drops during WRITE: pulse completes, then idle.
    bus.FrameActive = 1'b1;
    tick();
    send_byte(8'h04);
    send_byte(8'h3C);
    bus.FrameActive = 1'b0;
    check("drop_wr_hold", 32'(bus.RegHold), 32'h10);
    check("drop_wr_data", 32'(bus.RegData), 32'h3C);
    exp_pulses++;
    m_last = 8'h3C;
    tick();
    check("drop_wr_after", 32'(bus.RegHold), 32'd0);
    check("drop_wr_idle", 32'(bus.ByteReady), 32'd0);
    tick();

    // Byte and frame drop in the same cycle: byte ignored.
    bus.FrameActive = 1'b1;
    tick();
    send_byte(8'h07);
    bus.FrameActive = 1'b0;
    bus.ByteValid   = 1'b1;
    bus.ByteIn      = 8'hEE;
    tick();
    bus.ByteValid = 1'b0;
    check("same_cyc_hold", 32'(bus.RegHold), 32'd0);
    check("same_cyc_idle", 32'(bus.ByteReady), 32'd0);
    check("same_cyc_data", 32'(bus.RegData), 32'(m_last));
    tick();

    // Reset during WRITE clears outputs without waiting for an edge.
    bus.FrameActive = 1'b1;
    tick();
    send_byte(8'h01);
    send_byte(8'h5A);
    check("pre_rst_hold", 32'(bus.RegHold), 32'h02);
    #1 RST = 1'b1;
    #1;
    check("async_rst_hold", 32'(bus.RegHold), 32'd0);
    check("async_rst_data", 32'(bus.RegData), 32'd0);
    check("async_rst_ready", 32'(bus.ByteReady), 32'd0);
    m_last = 8'h00;
    tick();
    RST = 1'b0;
    tick();
    check("rel_addr_ready", 32'(bus.ByteReady), 32'd1);
    send_byte(8'h84);
    send_byte(8'h77);
    check("rel_hold", 32'(bus.RegHold), 32'h10);
    check("rel_data", 32'(bus.RegData), 32'h77);
    exp_pulses++;
    m_last = 8'h77;
    bus.FrameActive = 1'b0;
    repeat (2) tick();

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      a = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))};
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
      run_frame(a, n);
    end

    repeat (2) tick();
    check("pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
